// File: rtl/cdc_pkg.sv
// Shared types and limits for the multi-channel async-input receiver.
package cdc_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int SYNC_MIN_STAGES = 2;

    // True when a transition to new_level is one the selected mode reports.
    function automatic logic edge_hit(input edge_mode_e mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = new_level;
            EDGE_FALL: hit = ~new_level;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cdc_sync_cell.sv
// Single-bit flop chain that brings an asynchronous input into clk_i.
module cdc_sync_cell
    import cdc_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    output logic sync_o
);

    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("cdc_sync_cell: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0] chain_reg;

    // Plain shift chain: nothing may sit between stages or metastability can leak.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_reg <= {STAGES{RST_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], data_i};
        end
    end

    assign sync_o = chain_reg[STAGES-1];

endmodule

// File: rtl/cdc_sync_filt_edge.sv
// WIDTH-channel async receiver: synchronise, glitch-filter, detect edges, latch sticky flags.
module cdc_sync_filt_edge
    import cdc_pkg::*;
#(
    parameter int   WIDTH    = 4,
    parameter int   STAGES   = 2,
    parameter int   FILT_CNT = 3,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     data_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [WIDTH-1:0]     clear_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [WIDTH-1:0]     pulse_o,
    output logic [WIDTH-1:0]     flag_o
);

    localparam int               CNT_W    = $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    generate
        if (FILT_CNT < 1) begin : g_bad_filt
            $error("cdc_sync_filt_edge: FILT_CNT must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] pulse_reg;
    logic [WIDTH-1:0] flag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            edge_mode_e       mode;

            assign mode = edge_mode_e'(mode_i[2*gi +: 2]);

            cdc_sync_cell #(
                .STAGES  (STAGES),
                .RST_VAL (RST_VAL)
            ) u_sync (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .data_i (data_i[gi]),
                .sync_o (sync[gi])
            );

            // The level only moves after FILT_CNT consecutive differing samples;
            // the pulse is produced in that same update so it lines up with data_o.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg       <= '0;
                    data_reg[gi]  <= RST_VAL;
                    pulse_reg[gi] <= 1'b0;
                end else if (sync[gi] == data_reg[gi]) begin
                    cnt_reg       <= '0;
                    pulse_reg[gi] <= 1'b0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg       <= '0;
                    data_reg[gi]  <= sync[gi];
                    pulse_reg[gi] <= edge_hit(mode, sync[gi]);
                end else begin
                    cnt_reg       <= cnt_reg + CNT_W'(1);
                    pulse_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // A pulse outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_reg <= '0;
        end else begin
            flag_reg <= (flag_reg & ~clear_i) | pulse_reg;
        end
    end

    assign data_o  = data_reg;
    assign pulse_o = pulse_reg;
    assign flag_o  = flag_reg;

endmodule

// File: tb/tb_cdc_sync_filt_edge.sv
// Scoreboard bench: a window-based reference model predicts levels, flags and pulse events.
module tb_cdc_sync_filt_edge;

    localparam int   W  = 4;
    localparam int   ST = 2;
    localparam int   FC = 3;
    localparam logic RV = 1'b0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   data_i = '0;
    logic [2*W-1:0] mode_i = '0;
    logic [W-1:0]   clear_i = '0;
    logic [W-1:0]   data_o, pulse_o, flag_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cdc_sync_filt_edge #(
        .WIDTH    (W),
        .STAGES   (ST),
        .FILT_CNT (FC),
        .RST_VAL  (RV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .clear_i (clear_i),
        .data_o  (data_o),
        .pulse_o (pulse_o),
        .flag_o  (flag_o)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] pulse;
    } ev_t;

    ev_t          exp_q[$];
    logic [W-1:0] hist_q[$];
    logic [W-1:0] win[FC];
    logic [W-1:0] m_data, m_pulse, m_flag;
    int           cyc = 0;

    function automatic logic want_edge(input logic [1:0] m, input logic newv);
        return (m == 2'b11) || (m == 2'b01 && newv) || (m == 2'b10 && !newv);
    endfunction

    // Reference: an input sample reaches the filter ST edges after capture; the level
    // flips once the last FC filter inputs all disagree with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q = {};
            for (int i = 0; i < ST; i++) hist_q.push_front({W{RV}});
            for (int j = 0; j < FC; j++) win[j] = {W{RV}};
            m_data  = {W{RV}};
            m_pulse = '0;
            m_flag  = '0;
            exp_q   = {};
        end else begin
            logic [W-1:0] f;
            logic [W-1:0] np;
            logic         all_diff;
            cyc++;
            m_flag = (m_flag & ~clear_i) | m_pulse;
            f = hist_q.pop_back();
            hist_q.push_front(data_i);
            for (int j = FC - 1; j > 0; j--) win[j] = win[j-1];
            win[0] = f;
            np = '0;
            for (int k = 0; k < W; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FC; j++)
                    if (win[j][k] == m_data[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_data[k] = ~m_data[k];
                    np[k] = want_edge(mode_i[2*k +: 2], m_data[k]);
                end
            end
            m_pulse = np;
            if (np != '0) exp_q.push_back('{cyc, np});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            tests++;
            if (data_o !== {W{RV}} || pulse_o !== '0 || flag_o !== '0) begin
                fails++;
                $display("FAIL reset_state: data=%b pulse=%b flag=%b, required data=%b pulse=0000 flag=0000",
                         data_o, pulse_o, flag_o, {W{RV}});
            end
        end else begin
            tests++;
            if (data_o !== m_data || flag_o !== m_flag) begin
                fails++;
                $display("FAIL level cyc=%0d: data=%b flag=%b, required data=%b flag=%b",
                         cyc, data_o, flag_o, m_data, m_flag);
            end
            if (pulse_o !== '0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse cyc=%0d: pulse=%b, required none", cyc, pulse_o);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pulse !== pulse_o) begin
                        fails++;
                        $display("FAIL pulse cyc=%0d: pulse=%b, required pulse=%b at cyc=%0d",
                                 cyc, pulse_o, e.pulse, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_pulse cyc=%0d: pulse=0000, required pulse=%b", cyc, exp_q[0].pulse);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: rise on channel 0
        cycles(3);
        rst_n = 1'b1;
        mode_i = 8'b0000_0001;
        data_i[0] = 1'b1;
        cycles(10);
        tests++;
        if (flag_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL flag_sticky: flag0=%b, required 1", flag_o[0]);
        end

        // 2: glitch filter on channel 1, mode both
        mode_i[3:2] = 2'b11;
        data_i[1] = 1'b1; cycles(1); data_i[1] = 1'b0; cycles(6);
        data_i[1] = 1'b1; cycles(2); data_i[1] = 1'b0; cycles(6);
        tests++;
        if (data_o[1] !== 1'b0 || flag_o[1] !== 1'b0) begin
            fails++;
            $display("FAIL glitch_reject: data1=%b flag1=%b, required 0 0", data_o[1], flag_o[1]);
        end
        data_i[1] = 1'b1; cycles(3); data_i[1] = 1'b0; cycles(10);

        // 3: mode qualification on channel 2
        mode_i[5:4] = 2'b10;
        data_i[2] = 1'b1; cycles(8); data_i[2] = 1'b0; cycles(8);
        mode_i[5:4] = 2'b00;
        data_i[2] = 1'b1; cycles(8); data_i[2] = 1'b0; cycles(8);

        // 4: set/clear collision on channel 0
        clear_i = 4'b1111; cycles(1); clear_i = '0;
        mode_i[1:0] = 2'b11;
        data_i[0] = 1'b0;
        begin
            int n;
            n = 0;
            while (pulse_o[0] !== 1'b1 && n < 20) begin
                cycles(1);
                n++;
            end
            tests++;
            if (pulse_o[0] !== 1'b1) begin
                fails++;
                $display("FAIL wait_pulse0: no pulse within 20 cycles, required one");
            end
        end
        clear_i[0] = 1'b1;
        cycles(1);
        tests++;
        if (flag_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL set_wins: flag0=%b, required 1", flag_o[0]);
        end
        cycles(1);
        clear_i[0] = 1'b0;
        tests++;
        if (flag_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL clear: flag0=%b, required 0", flag_o[0]);
        end
        cycles(4);

        // 5: all channels together, then reset mid-filter
        mode_i = 8'hFF;
        data_i = 4'b1111; cycles(8);
        data_i = 4'b0000; cycles(2);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (data_o !== 4'b0000 || pulse_o !== 4'b0000 || flag_o !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset: data=%b pulse=%b flag=%b, required all 0000",
                     data_o, pulse_o, flag_o);
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(10);

        // 6: reset release with inputs away from reset value
        rst_n = 1'b0;
        data_i = 4'b0101;
        mode_i = 8'b0101_0101;
        cycles(2);
        rst_n = 1'b1;
        cycles(8);

        // Randomised traffic: short toggles exercise the filter, modes and clears move freely
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < W; k++)
                if ($urandom_range(0, 3) == 0) data_i[k] = ~data_i[k];
            if ($urandom_range(0, 15) == 0) mode_i = 8'($urandom);
            clear_i = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cycles(1);
        end
        clear_i = '0;
        cycles(12);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d pulses outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
